lsu_queue: RTL and testbench
============================

LSU_QUEUE -- requirements
Module: lsu_queue

Interface
REQ-001 Parameter DEPTH, default 2, meaning max requests issued to MMU but not yet delivered to WB (1..8).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 cancel  in  1  pipeline flush, squashes all queued/in-flight results.
REQ-005 req_valid  in  1  ex1 presents a memory op; req_ready  out  1  op consumed this cycle.
REQ-006 base, offset  in  32 each  address operands; mem_type  in  mem_type_t; mem_size  in  mem_size_t; st_data  in  32.
REQ-007 have_excp  out  1; excp_type  out  excp_t  combinational exception for the presented op.
REQ-008 ok  out  1; accept_ok  in  1; ld_data  out  32  in-order result handshake to WB.
REQ-009 mmu_req, mmu_we  out  1; mmu_addr, mmu_wdata  out  32; mmu_size  out  2; mmu_wstrb  out  4; mmu_addr_ok, mmu_data_ok  in  1; mmu_rdata  in  32; mmu_tlbr, mmu_pil, mmu_pis, mmu_ppi, mmu_pme  in  1.

Function
REQ-010 addr = base + offset, modulo 2^32; mmu_addr = addr.
REQ-011 credits = inflight + resp_cnt; full = (credits == DEPTH).
REQ-012 have_excp priority when req_valid: ALE (half addr[0], word addr[1:0]!=0), then TLBR, PIL, PIS, PPI, PME; else 0, excp_type = ALE.
REQ-013 mmu_req = req_valid && !full && !cancel && !ALE.
REQ-014 req_ready = !cancel && (have_excp || (mmu_req && mmu_addr_ok)); excepting op consumed without entering queue.
REQ-015 Issue (mmu_req && mmu_addr_ok && !have_excp): push {addr[1:0], mem_type, mem_size} into meta FIFO, inflight +1.
REQ-016 mmu_we, mmu_size, mmu_wstrb, mmu_wdata: byte -> strobe 1<<addr[1:0], data {4{b}}; half -> 0011/1100 by addr[1], data {2{h}}; word -> 1111; loads strobe 0000.
REQ-017 mmu_data_ok pops meta head, inflight -1; ld_data formatted from head: byte/half lane select, sign-extend only for MEM_LOAD_S, word passthrough; stores yield 0.
REQ-018 ok = (resp_cnt != 0) || (mmu_data_ok && discard == 0); ld_data = resp head if resp_cnt != 0 else formatted data (bypass, 0 latency).
REQ-019 Formatted result pushed into resp FIFO unless bypassed and accept_ok same cycle; accept_ok pops resp head when resp_cnt != 0.
REQ-020 Credit rule guarantees resp FIFO never overflows; mmu_data_ok with inflight == 0 is illegal (assert).
REQ-021 cancel: resp FIFO cleared, discard <= inflight - (mmu_data_ok ? 1 : 0) (still counted in inflight); no issue that cycle; ok forced 0 that cycle.
REQ-022 mmu_data_ok while discard != 0: pop meta, inflight -1, discard -1, no ok, no push.
REQ-023 Simultaneous issue and data_ok: inflight unchanged; simultaneous push/pop of resp: resp_cnt unchanged.
REQ-024 Strict in-order results; accept_ok with ok=0 ignored.

Reset
REQ-025 On reset assertion (async): inflight=0, resp_cnt=0, discard=0, FIFO pointers=0; outputs req_ready, ok, mmu_req =0 while req_valid=0.
REQ-026 FIFO payload storage not reset.
REQ-027 Reset mid-transaction drops all state; MMU assumed reset in same cycle.

Structure
REQ-028 mem_type_t, mem_size_t, excp_t remain in shared definitions header; no new typedefs there beyond an lsu_meta_t struct.
REQ-029 One sub-module: sync_fifo (parameters WIDTH, DEPTH; async reset), instantiated twice (meta, resp).
REQ-030 Counter widths $clog2(DEPTH+1).

Verification
REQ-031 DEPTH=2, LD.W base=0x1000 offset=4, addr_ok same cycle, data_ok next with rdata=0xDEADBEEF, accept_ok=1 -> ok and ld_data=0xDEADBEEF that cycle, no buffering.
REQ-032 Three back-to-back LD.B at 0x1001, addr_ok always 1, data_ok held 0 -> 3rd req_ready=0 (full); then rdata=0x0000_8000 -> ld_data=0xFFFFFF80 signed, 0x00000080 unsigned.
REQ-033 accept_ok=0 for 2 data_ok returns (0x11, 0x22), then accept_ok=1 -> ok held, ld_data 0x11 then 0x22, in order.
REQ-034 LD.H at 0x1003 -> have_excp=1 ALE, mmu_req=0, req_ready=1; LD.W with mmu_tlbr=1 -> TLBR, nothing queued.
REQ-035 Two loads in flight, cancel pulse, then two data_ok -> ok never asserted, discard 2->0, next load completes normally.
REQ-036 ST.H st_data=0x1234ABCD at 0x2002 -> mmu_we=1, wstrb=1100, wdata=0xABCDABCD, size=1.

Source files
------------

// File: rtl/lsu_queue_pkg.sv
// Shared LSU definitions: memory op encodings, exception codes and the
// per-request metadata carried from issue to result formatting.
package lsu_queue_pkg;

    typedef enum logic [1:0] {
        MEM_LOAD_S = 2'd0,
        MEM_LOAD_U = 2'd1,
        MEM_STORE  = 2'd2
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        EXCP_ALE  = 3'd0,
        EXCP_TLBR = 3'd1,
        EXCP_PIL  = 3'd2,
        EXCP_PIS  = 3'd3,
        EXCP_PPI  = 3'd4,
        EXCP_PME  = 3'd5
    } excp_t;

    typedef struct packed {
        logic [1:0] offset;
        mem_type_t  mem_type;
        mem_size_t  mem_size;
    } lsu_meta_t;

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_HALF: return offset[0];
            MEM_WORD: return offset != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; any DEPTH >= 1.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; the count guarantees stale entries
    // are never read, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lsu_queue.sv
// Load/store queue between ex1, the MMU and writeback: issues ops, tracks
// in-flight requests, formats load data and returns results strictly in order.
module lsu_queue
    import lsu_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cancel,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  mem_type_t   mem_type,
    input  mem_size_t   mem_size,
    input  logic [31:0] st_data,
    output logic        have_excp,
    output excp_t       excp_type,
    output logic        ok,
    input  logic        accept_ok,
    output logic [31:0] ld_data,
    output logic        mmu_req,
    output logic        mmu_we,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic [1:0]  mmu_size,
    output logic [3:0]  mmu_wstrb,
    input  logic        mmu_addr_ok,
    input  logic        mmu_data_ok,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_tlbr,
    input  logic        mmu_pil,
    input  logic        mmu_pis,
    input  logic        mmu_ppi,
    input  logic        mmu_pme
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   addr;
    logic          ale;
    logic [CW-1:0] inflight;
    logic [CW-1:0] resp_cnt;
    logic [CW-1:0] discard;
    logic [CW:0]   credits;
    logic          full;
    logic          issue;
    logic          deliver;
    logic          push_resp;
    logic          pop_resp;
    lsu_meta_t     meta_in;
    lsu_meta_t     meta_head;
    logic [31:0]   fmt_data;
    logic [31:0]   resp_head;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;

    assign addr     = base + offset;
    assign mmu_addr = addr;
    assign ale      = req_valid && is_misaligned(mem_size, addr[1:0]);

    assign credits = {1'b0, inflight} + {1'b0, resp_cnt};
    assign full    = (credits == (CW+1)'(DEPTH));

    // NOTE: every combinational output gets a default before the priority
    // chain so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        have_excp = 1'b0;
        excp_type = EXCP_ALE;
        if (req_valid) begin
            have_excp = 1'b1;
            if      (ale)      excp_type = EXCP_ALE;
            else if (mmu_tlbr) excp_type = EXCP_TLBR;
            else if (mmu_pil)  excp_type = EXCP_PIL;
            else if (mmu_pis)  excp_type = EXCP_PIS;
            else if (mmu_ppi)  excp_type = EXCP_PPI;
            else if (mmu_pme)  excp_type = EXCP_PME;
            else               have_excp = 1'b0;
        end
    end

    assign mmu_req   = req_valid && !full && !cancel && !ale;
    assign req_ready = !cancel && (have_excp || (mmu_req && mmu_addr_ok));
    assign issue     = mmu_req && mmu_addr_ok && !have_excp;

    always_comb begin
        mmu_we    = (mem_type == MEM_STORE);
        mmu_size  = mem_size;
        mmu_wdata = st_data;
        mmu_wstrb = 4'b1111;
        case (mem_size)
            MEM_BYTE: begin
                mmu_wdata = {4{st_data[7:0]}};
                mmu_wstrb = 4'b0001 << addr[1:0];
            end
            MEM_HALF: begin
                mmu_wdata = {2{st_data[15:0]}};
                mmu_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!mmu_we) mmu_wstrb = 4'b0000;
    end

    assign meta_in = '{offset: addr[1:0], mem_type: mem_type, mem_size: mem_size};

    sync_fifo #(
        .WIDTH($bits(lsu_meta_t)),
        .DEPTH(DEPTH)
    ) u_meta_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (issue),
        .pop   (mmu_data_ok),
        .wdata (meta_in),
        .rdata (meta_head),
        .count (inflight)
    );

    assign byte_lane = 8'(mmu_rdata >> {meta_head.offset, 3'b000});
    assign half_lane = meta_head.offset[1] ? mmu_rdata[31:16] : mmu_rdata[15:0];

    always_comb begin
        fmt_data = 32'h0;
        if (meta_head.mem_type != MEM_STORE) begin
            case (meta_head.mem_size)
                MEM_BYTE: fmt_data = (meta_head.mem_type == MEM_LOAD_S)
                                   ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
                MEM_HALF: fmt_data = (meta_head.mem_type == MEM_LOAD_S)
                                   ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
                default:  fmt_data = mmu_rdata;
            endcase
        end
    end

    // A fresh result bypasses the resp FIFO only when nothing older is waiting.
    assign deliver   = mmu_data_ok && (discard == '0) && !cancel;
    assign ok        = !cancel && ((resp_cnt != '0) || deliver);
    assign ld_data   = (resp_cnt != '0) ? resp_head : fmt_data;
    assign push_resp = deliver && !((resp_cnt == '0) && accept_ok);
    assign pop_resp  = !cancel && accept_ok && (resp_cnt != '0);

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (cancel),
        .push  (push_resp),
        .pop   (pop_resp),
        .wdata (fmt_data),
        .rdata (resp_head),
        .count (resp_cnt)
    );

    // Squashed requests stay counted in inflight until the MMU returns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard <= '0;
        end else if (cancel) begin
            discard <= inflight - CW'(mmu_data_ok);
        end else if (mmu_data_ok && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    assert property (@(posedge clk) disable iff (reset) mmu_data_ok |-> (inflight != '0));

endmodule

// File: tb/tb_lsu_queue.sv
// Directed testbench for lsu_queue (DEPTH=2) with hand-computed expectations.
module tb_lsu_queue;
    import lsu_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] base;
    logic [31:0] offset;
    mem_type_t   mem_type;
    mem_size_t   mem_size;
    logic [31:0] st_data;
    logic        have_excp;
    excp_t       excp_type;
    logic        ok;
    logic        accept_ok;
    logic [31:0] ld_data;
    logic        mmu_req;
    logic        mmu_we;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic [1:0]  mmu_size;
    logic [3:0]  mmu_wstrb;
    logic        mmu_addr_ok;
    logic        mmu_data_ok;
    logic [31:0] mmu_rdata;
    logic        mmu_tlbr;
    logic        mmu_pil;
    logic        mmu_pis;
    logic        mmu_ppi;
    logic        mmu_pme;

    int tests_run    = 0;
    int tests_failed = 0;

    lsu_queue #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cancel      (cancel),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .base        (base),
        .offset      (offset),
        .mem_type    (mem_type),
        .mem_size    (mem_size),
        .st_data     (st_data),
        .have_excp   (have_excp),
        .excp_type   (excp_type),
        .ok          (ok),
        .accept_ok   (accept_ok),
        .ld_data     (ld_data),
        .mmu_req     (mmu_req),
        .mmu_we      (mmu_we),
        .mmu_addr    (mmu_addr),
        .mmu_wdata   (mmu_wdata),
        .mmu_size    (mmu_size),
        .mmu_wstrb   (mmu_wstrb),
        .mmu_addr_ok (mmu_addr_ok),
        .mmu_data_ok (mmu_data_ok),
        .mmu_rdata   (mmu_rdata),
        .mmu_tlbr    (mmu_tlbr),
        .mmu_pil     (mmu_pil),
        .mmu_pis     (mmu_pis),
        .mmu_ppi     (mmu_ppi),
        .mmu_pme     (mmu_pme)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input mem_type_t t, input mem_size_t s, input logic [31:0] b,
                      input logic [31:0] o, input logic [31:0] sd);
        req_valid = 1'b1;
        mem_type  = t;
        mem_size  = s;
        base      = b;
        offset    = o;
        st_data   = sd;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic ret(input logic [31:0] data, input logic acc);
        mmu_data_ok = 1'b1;
        mmu_rdata   = data;
        accept_ok   = acc;
        #1;
    endtask

    task automatic ret_off();
        mmu_data_ok = 1'b0;
        accept_ok   = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; req_valid = 1'b0;
        base = '0; offset = '0; mem_type = MEM_LOAD_S; mem_size = MEM_WORD; st_data = '0;
        accept_ok = 1'b0; mmu_addr_ok = 1'b1; mmu_data_ok = 1'b0; mmu_rdata = '0;
        mmu_tlbr = 1'b0; mmu_pil = 1'b0; mmu_pis = 1'b0; mmu_ppi = 1'b0; mmu_pme = 1'b0;
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_ok", 32'(ok), 32'd0);
        check("reset_mmu_req", 32'(mmu_req), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Single LD.W with bypass delivery
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h4, 32'h0);
        check("ldw_mmu_req", 32'(mmu_req), 32'd1);
        check("ldw_addr", mmu_addr, 32'h1004);
        check("ldw_req_ready", 32'(req_ready), 32'd1);
        check("ldw_wstrb", 32'(mmu_wstrb), 32'h0);
        check("ldw_we", 32'(mmu_we), 32'd0);
        tick();
        idle();
        ret(32'hDEADBEEF, 1'b1);
        check("ldw_ok", 32'(ok), 32'd1);
        check("ldw_data", ld_data, 32'hDEADBEEF);
        tick();
        ret_off();
        check("ldw_no_buffer", 32'(ok), 32'd0);

        // Three LD.B at 0x1001: third blocked by credits
        op(MEM_LOAD_S, MEM_BYTE, 32'h1000, 32'h1, 32'h0);
        check("ldb1_ready", 32'(req_ready), 32'd1);
        tick();
        op(MEM_LOAD_U, MEM_BYTE, 32'h1000, 32'h1, 32'h0);
        check("ldb2_ready", 32'(req_ready), 32'd1);
        tick();
        op(MEM_LOAD_S, MEM_BYTE, 32'h1000, 32'h1, 32'h0);
        check("ldb3_full_ready", 32'(req_ready), 32'd0);
        check("ldb3_full_mmu_req", 32'(mmu_req), 32'd0);
        idle();
        ret(32'h0000_8000, 1'b1);
        check("ldb_signed", ld_data, 32'hFFFFFF80);
        check("ldb_signed_ok", 32'(ok), 32'd1);
        tick();
        ret(32'h0000_8000, 1'b1);
        check("ldb_unsigned", ld_data, 32'h00000080);
        tick();
        ret_off();

        // Back-pressure: results buffered, delivered in order
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        tick();
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        tick();
        idle();
        ret(32'h11, 1'b0);
        check("bp_first_ok", 32'(ok), 32'd1);
        check("bp_first_data", ld_data, 32'h11);
        tick();
        ret(32'h22, 1'b0);
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("bp_full_mmu_req", 32'(mmu_req), 32'd0);
        check("bp_head_held", ld_data, 32'h11);
        idle();
        tick();
        ret_off();
        accept_ok = 1'b1; #1;
        check("bp_drain1_ok", 32'(ok), 32'd1);
        check("bp_drain1_data", ld_data, 32'h11);
        tick();
        check("bp_drain2_ok", 32'(ok), 32'd1);
        check("bp_drain2_data", ld_data, 32'h22);
        tick();
        accept_ok = 1'b0; #1;
        check("bp_empty_ok", 32'(ok), 32'd0);

        // Exceptions: ALE, TLBR, priority PIL over PME
        op(MEM_LOAD_S, MEM_HALF, 32'h1000, 32'h3, 32'h0);
        check("ale_have", 32'(have_excp), 32'd1);
        check("ale_type", 32'(excp_type), 32'(EXCP_ALE));
        check("ale_mmu_req", 32'(mmu_req), 32'd0);
        check("ale_ready", 32'(req_ready), 32'd1);
        tick();
        mmu_tlbr = 1'b1;
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("tlbr_have", 32'(have_excp), 32'd1);
        check("tlbr_type", 32'(excp_type), 32'(EXCP_TLBR));
        check("tlbr_ready", 32'(req_ready), 32'd1);
        tick();
        mmu_tlbr = 1'b0; mmu_pil = 1'b1; mmu_pme = 1'b1; #1;
        check("pil_prio_type", 32'(excp_type), 32'(EXCP_PIL));
        mmu_pil = 1'b0; mmu_pme = 1'b0;
        idle();
        check("noexcp_have", 32'(have_excp), 32'd0);
        check("noexcp_type", 32'(excp_type), 32'(EXCP_ALE));

        // Cancel with two loads in flight (exceptions left nothing queued)
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("cx_issue1", 32'(req_ready), 32'd1);
        tick();
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("cx_issue2", 32'(req_ready), 32'd1);
        tick();
        cancel = 1'b1; #1;
        check("cx_cancel_mmu_req", 32'(mmu_req), 32'd0);
        check("cx_cancel_ready", 32'(req_ready), 32'd0);
        check("cx_cancel_ok", 32'(ok), 32'd0);
        idle();
        tick();
        cancel = 1'b0; #1;
        check("cx_discard2", 32'(dut.discard), 32'd2);
        ret(32'hBAD0, 1'b1);
        check("cx_drop1_ok", 32'(ok), 32'd0);
        tick();
        ret(32'hBAD1, 1'b1);
        check("cx_drop2_ok", 32'(ok), 32'd0);
        tick();
        ret_off();
        check("cx_discard0", 32'(dut.discard), 32'd0);
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        tick();
        idle();
        ret(32'h55, 1'b1);
        check("cx_after_ok", 32'(ok), 32'd1);
        check("cx_after_data", ld_data, 32'h55);
        tick();
        ret_off();

        // Stores
        op(MEM_STORE, MEM_HALF, 32'h2000, 32'h2, 32'h1234ABCD);
        check("sth_we", 32'(mmu_we), 32'd1);
        check("sth_wstrb", 32'(mmu_wstrb), 32'hC);
        check("sth_wdata", mmu_wdata, 32'hABCDABCD);
        check("sth_size", 32'(mmu_size), 32'd1);
        tick();
        idle();
        ret(32'hFFFFFFFF, 1'b1);
        check("sth_ok", 32'(ok), 32'd1);
        check("sth_result_zero", ld_data, 32'h0);
        tick();
        ret_off();
        mmu_addr_ok = 1'b0;
        op(MEM_STORE, MEM_BYTE, 32'h2000, 32'h3, 32'h1234ABCD);
        check("stb_wstrb", 32'(mmu_wstrb), 32'h8);
        check("stb_wdata", mmu_wdata, 32'hCDCDCDCD);
        check("stb_no_addr_ok_ready", 32'(req_ready), 32'd0);
        idle();
        mmu_addr_ok = 1'b1;

        // Half loads on upper lane with address wraparound
        op(MEM_LOAD_U, MEM_HALF, 32'hFFFFFFFE, 32'h1004, 32'h0);
        check("wrap_addr", mmu_addr, 32'h1002);
        tick();
        op(MEM_LOAD_S, MEM_HALF, 32'hFFFFFFFE, 32'h1004, 32'h0);
        tick();
        idle();
        ret(32'h87654321, 1'b1);
        check("ldhu_data", ld_data, 32'h00008765);
        tick();
        ret(32'h87654321, 1'b1);
        check("ldh_data", ld_data, 32'hFFFF8765);
        tick();
        ret_off();

        // Reset mid-transaction clears all tracking
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        tick();
        idle();
        reset = 1'b1; #1;
        check("rst_mid_inflight", 32'(dut.inflight), 32'd0);
        check("rst_mid_ok", 32'(ok), 32'd0);
        tick();
        reset = 1'b0;
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("rst_after_issue1", 32'(req_ready), 32'd1);
        tick();
        op(MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h0, 32'h0);
        check("rst_after_issue2", 32'(req_ready), 32'd1);
        tick();
        idle();
        ret(32'h77, 1'b1);
        check("rst_after_data1", ld_data, 32'h77);
        tick();
        ret(32'h88, 1'b1);
        check("rst_after_data2", ld_data, 32'h88);
        tick();
        ret_off();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
